regmap_ctrl: RTL and testbench
==============================

Name: regmap_ctrl

Overview:
Parametrised control/status register file for the accelerator host interface. It replaces the fixed 8-entry write-only map with the following:
- a CTRL register with a self-clearing START pulse;
- N configurable RW config registers exported to the datapath;
- a W1C interrupt-status register;
- M read-only status registers;
- byte-strobed writes, a 1-cycle registered read path, and error signalling on unmapped addresses.

It sits between the host bus adapter and the sparse-vector compute core.

Parameters:
ADDR_WIDTH, 8, address width; the map must satisfy NUM_CFG+NUM_STAT+2 <= 2**ADDR_WIDTH.
DATA_WIDTH, 32, register width; must be a multiple of 8.
NUM_CFG, 8, number of RW config registers (e.g. vector dimension, base pointers).
NUM_STAT, 4, number of RO status registers.
ERR_DATA, 32'hDEADDEAD, read data returned for unmapped addresses (truncated/zero-extended to DATA_WIDTH).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
wr_en  in  1  write request, single-cycle
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_strb  in  DATA_WIDTH/8  byte enables; bit i gates wr_data[8i+7:8i]
wr_err  out  1  one-cycle pulse, write to unmapped or RO address
rd_en  in  1  read request, single-cycle
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  read data, registered
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_err  out  1  qualifies rd_valid; read hit an unmapped address
cfg_out  out  NUM_CFG*DATA_WIDTH  flat config registers, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
start_pulse  out  1  one-cycle pulse from CTRL.START
status_in  in  NUM_STAT*DATA_WIDTH  hardware status, sampled live
hw_event  in  DATA_WIDTH  per-bit event pulses setting IRQ_STAT bits
irq  out  1  level interrupt, registered

Behaviour:
- Address map:
  - 0x00 CTRL. Bit0 START is write-1-to-pulse and always reads 0. Bit1 IRQ_EN is RW. Bits above 1 are RW scratch.
  - 1..NUM_CFG: CFG[0..NUM_CFG-1], RW.
  - NUM_CFG+1: IRQ_STAT, W1C.
  - NUM_CFG+2..NUM_CFG+NUM_STAT+1: STAT[0..NUM_STAT-1], RO.
  - All other addresses are unmapped.
- Reset (rst=0, asynchronous): all registers to 0; rd_data=0, rd_valid=0, rd_err=0, wr_err=0, start_pulse=0, irq=0. Reset asserted mid-access aborts the access; no output pulses after reset deassertion.
- Write:
  - Takes effect at the clk edge where wr_en=1. Only bytes with wr_strb=1 update.
  - start_pulse=1 on the following cycle iff wr_en, addr 0, wr_strb[0], and wr_data[0] are all set.
  - cfg_out reflects the new value on the next cycle.
- W1C: an IRQ_STAT bit clears when written 1 with its strobe set. In the same cycle, hw_event bit=1 sets it. If set and clear hit the same bit in one cycle, set wins.
- Write to a RO or unmapped address: no state change; wr_err=1 for exactly one cycle after the request.
- Read:
  - rd_en sampled at edge N; rd_valid=1 for one cycle at N+1 with rd_data.
  - rd_data holds its value until the next read completes.
  - Unmapped read returns ERR_DATA with rd_err=1.
  - rd_err=0 whenever rd_valid=0.
- STAT reads return status_in as sampled at edge N.
- Simultaneous read and write to the same address: the read returns the pre-write value (read-before-write).
- Simultaneous access to different addresses: both complete independently.
- irq is registered: irq = IRQ_EN & |IRQ_STAT, one cycle after the contributing register change.
- Addresses are not wrapped or aliased; every index >= NUM_CFG+NUM_STAT+2 is unmapped.
- Back-to-back reads every cycle are supported at full throughput: one rd_valid per rd_en, in order.

Test Plan:
1. Reset: rst=0 with random inputs → all outputs 0. Release, then read 0x01 → rd_valid at +1, rd_data=0, rd_err=0.
2. Config write with strobes: write 0x01 data=0x0000C350 strb=4'hF, then write 0x01 data=0xFFFFFFFF strb=4'b0010 → read 0x01 returns 0x0000FF50; cfg_out[31:0]=0x0000FF50.
3. START/IRQ_EN: write 0x00 data=0x3 → start_pulse high exactly one cycle; read 0x00 returns 0x2.
4. Interrupt: with IRQ_EN=1, pulse hw_event=0x5 → IRQ_STAT=0x5 and irq=1. Write 0x1 to IRQ_STAT (NUM_CFG+1) while hw_event=0x1 → IRQ_STAT stays 0x5 (set wins). Next, write 0x5 with no event → IRQ_STAT=0 and irq=0 one cycle later.
5. Errors: read addr 0xFF → rd_data=0xDEADDEAD, rd_err=1. Write to STAT[0] (addr NUM_CFG+2) → wr_err one-cycle pulse; STAT read still equals status_in.
6. Collision and throughput: reads to 0x01, 0x02, 0x03 on consecutive cycles with a simultaneous write of 0xA5 to 0x02 in the first read's cycle → three consecutive rd_valid. Reads return the old 0x01, the new 0xA5 at 0x02 (written earlier), and 0x03. Same-cycle read/write to 0x04 returns the old value.

Source files
------------

// File: rtl/regmap_if.sv
// Host register-access bus between the host bus adapter and regmap_ctrl.
//   master : drives write/read requests, receives wr_err and read response
//   slave  : receives requests, drives wr_err, rd_data, rd_valid, rd_err
// Write channel : wr_en, wr_addr, wr_data, wr_strb -> wr_err (1-cycle pulse)
// Read channel  : rd_en, rd_addr -> rd_data, rd_valid, rd_err (1 cycle later)
interface regmap_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_strb;
    logic                      wr_err;
    logic                      rd_en;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_valid;
    logic                      rd_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        input  wr_err, rd_data, rd_valid, rd_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        output wr_err, rd_data, rd_valid, rd_err
    );
endinterface

// File: rtl/regmap_ctrl.sv
// Control/status register file for the accelerator host interface.
// Map: 0 CTRL (bit0 START pulse, bit1 IRQ_EN, rest scratch), 1..NUM_CFG CFG (RW),
//      NUM_CFG+1 IRQ_STAT (W1C), NUM_CFG+2.. STAT (RO, live), everything else unmapped.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : regmap_if slave (byte-strobed writes, 1-cycle registered reads)
//   cfg_o          : flat config registers, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   start_pulse_o  : one-cycle pulse from CTRL.START
//   status_i       : hardware status words read through STAT
//   hw_event_i     : per-bit event pulses that set IRQ_STAT bits
//   irq_o          : registered level interrupt, IRQ_EN & |IRQ_STAT
module regmap_ctrl #(
    parameter int              ADDR_WIDTH = 8,
    parameter int              DATA_WIDTH = 32,
    parameter int              NUM_CFG    = 8,
    parameter int              NUM_STAT   = 4,
    parameter logic [31:0]     ERR_DATA   = 32'hDEADDEAD
) (
    input  logic                           clk,
    input  logic                           rst_n,
    regmap_if.slave                        bus,
    output logic [NUM_CFG*DATA_WIDTH-1:0]  cfg_o,
    output logic                           start_pulse_o,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] status_i,
    input  logic [DATA_WIDTH-1:0]          hw_event_i,
    output logic                           irq_o
);
    localparam int IRQ_IDX   = NUM_CFG + 1;
    localparam int STAT_BASE = NUM_CFG + 2;
    localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

    logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] cfg_q [NUM_CFG];
    logic [DATA_WIDTH-1:0] cfg_d [NUM_CFG];
    logic [DATA_WIDTH-1:0] irq_stat_q, irq_stat_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_err_q, rd_err_d;
    logic                  wr_err_q, wr_err_d;
    logic                  start_q, start_d;
    logic                  irq_q, irq_d;

    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_hit, wr_hit, wr_ctrl, wr_irq;

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++)
            wr_mask[8*b +: 8] = {8{bus.wr_strb[b]}};

        wr_ctrl = bus.wr_en && (bus.wr_addr == '0);
        wr_irq  = bus.wr_en && (bus.wr_addr == ADDR_WIDTH'(IRQ_IDX));
        wr_hit  = wr_ctrl || wr_irq;

        ctrl_d = ctrl_q;
        if (wr_ctrl)
            ctrl_d = (ctrl_q & ~wr_mask) | (bus.wr_data & wr_mask);
        // START is never stored so it always reads back as 0
        ctrl_d[0] = 1'b0;
        start_d   = wr_ctrl && bus.wr_strb[0] && bus.wr_data[0];

        cfg_d = cfg_q;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (bus.wr_en && (bus.wr_addr == ADDR_WIDTH'(k + 1))) begin
                cfg_d[k] = (cfg_q[k] & ~wr_mask) | (bus.wr_data & wr_mask);
                wr_hit   = 1'b1;
            end
        end

        // Event OR-ed in after the clear so a same-cycle set wins
        irq_stat_d = (irq_stat_q & ~(wr_irq ? (bus.wr_data & wr_mask) : '0)) | hw_event_i;
        wr_err_d   = bus.wr_en && !wr_hit;
        irq_d      = ctrl_q[1] && (|irq_stat_q);

        // Read mux sees only current register values: read-before-write on collision
        rd_word = ERR_WORD;
        rd_hit  = 1'b0;
        if (bus.rd_addr == '0) begin
            rd_word = ctrl_q;
            rd_hit  = 1'b1;
        end
        if (bus.rd_addr == ADDR_WIDTH'(IRQ_IDX)) begin
            rd_word = irq_stat_q;
            rd_hit  = 1'b1;
        end
        for (int k = 0; k < NUM_CFG; k++) begin
            if (bus.rd_addr == ADDR_WIDTH'(k + 1)) begin
                rd_word = cfg_q[k];
                rd_hit  = 1'b1;
            end
        end
        for (int s = 0; s < NUM_STAT; s++) begin
            if (bus.rd_addr == ADDR_WIDTH'(STAT_BASE + s)) begin
                rd_word = status_i[s*DATA_WIDTH +: DATA_WIDTH];
                rd_hit  = 1'b1;
            end
        end

        rd_data_d = bus.rd_en ? rd_word : rd_data_q;
        rd_err_d  = bus.rd_en && !rd_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            for (int k = 0; k < NUM_CFG; k++)
                cfg_q[k] <= '0;
            irq_stat_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            cfg_q      <= cfg_d;
            irq_stat_q <= irq_stat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= bus.rd_en;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
            start_q    <= start_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        cfg_o = '0;
        for (int k = 0; k < NUM_CFG; k++)
            cfg_o[k*DATA_WIDTH +: DATA_WIDTH] = cfg_q[k];
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.wr_err     = wr_err_q;
    assign start_pulse_o  = start_q;
    assign irq_o          = irq_q;
endmodule

// File: tb/tb_regmap_ctrl.sv
// Directed self-checking bench for regmap_ctrl (default map: CFG 1..8,
// IRQ_STAT 9, STAT 10..13, unmapped 14..255).
module tb_regmap_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NC = 8;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regmap_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic [NC*DW-1:0] cfg_o;
    logic             start_pulse_o;
    logic [NS*DW-1:0] status_i;
    logic [DW-1:0]    hw_event_i;
    logic             irq_o;

    int errors = 0;
    int checks = 0;

    regmap_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CFG(NC), .NUM_STAT(NS),
        .ERR_DATA(32'hDEADDEAD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .cfg_o(cfg_o),
        .start_pulse_o(start_pulse_o), .status_i(status_i),
        .hw_event_i(hw_event_i), .irq_o(irq_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        hw_event_i = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v, output logic e);
        bus.rd_en = 1'b1; bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
        d = bus.rd_data; v = bus.rd_valid; e = bus.rd_err;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        logic v, e;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'($urandom()); bus.wr_addr = AW'($urandom());
            bus.wr_data = $urandom(); bus.wr_strb = 4'($urandom());
            bus.rd_en = 1'($urandom()); bus.rd_addr = AW'($urandom());
            hw_event_i = $urandom(); status_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_flags: got %b%b expected 00", bus.rd_valid, bus.rd_err); end
        checks++; if (bus.wr_err !== 1'b0 || start_pulse_o !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b%b expected 000", bus.wr_err, start_pulse_o, irq_o); end
        checks++; if (cfg_o !== '0) begin errors++; $display("FAIL reset_cfg: got %h expected 0", cfg_o); end
        idle_inputs();
        status_i = '0;
        rst_n = 1'b1;
        tick();
        checks++; if (bus.rd_valid !== 1'b0 || bus.wr_err !== 1'b0 || start_pulse_o !== 1'b0) begin errors++; $display("FAIL post_reset_pulses: got %b%b%b expected 000", bus.rd_valid, bus.wr_err, start_pulse_o); end
        do_read(8'h01, d, v, e);
        checks++; if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL reset_read_cfg0: got v=%b e=%b d=%h expected v=1 e=0 d=0", v, e, d); end
    endtask

    task automatic test_cfg_strobe();
        logic [DW-1:0] d;
        logic v, e;
        do_write(8'h01, 32'h0000C350, 4'hF);
        do_write(8'h01, 32'hFFFFFFFF, 4'b0010);
        do_read(8'h01, d, v, e);
        checks++; if (d !== 32'h0000FF50 || v !== 1'b1) begin errors++; $display("FAIL cfg_strobe_read: got %h v=%b expected 0000ff50 v=1", d, v); end
        checks++; if (cfg_o[31:0] !== 32'h0000FF50) begin errors++; $display("FAIL cfg_strobe_out: got %h expected 0000ff50", cfg_o[31:0]); end
    endtask

    task automatic test_start();
        logic [DW-1:0] d;
        logic v, e;
        do_write(8'h00, 32'h3, 4'hF);
        checks++; if (start_pulse_o !== 1'b1) begin errors++; $display("FAIL start_high: got %b expected 1", start_pulse_o); end
        tick();
        checks++; if (start_pulse_o !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %b expected 0", start_pulse_o); end
        do_read(8'h00, d, v, e);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL ctrl_read: got %h expected 00000002", d); end
        // START with its byte strobe off must not pulse
        do_write(8'h00, 32'h3, 4'b1110);
        checks++; if (start_pulse_o !== 1'b0) begin errors++; $display("FAIL start_no_strb: got %b expected 0", start_pulse_o); end
    endtask

    task automatic test_irq();
        logic [DW-1:0] d;
        logic v, e;
        hw_event_i = 32'h5;
        tick();
        hw_event_i = '0;
        do_read(8'd9, d, v, e);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL irq_stat_set: got %h expected 00000005", d); end
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq_o); end
        hw_event_i = 32'h1;
        do_write(8'd9, 32'h1, 4'hF);
        hw_event_i = '0;
        do_read(8'd9, d, v, e);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL irq_set_wins: got %h expected 00000005", d); end
        do_write(8'd9, 32'h5, 4'hF);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_registered: got %b expected 1", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b expected 0", irq_o); end
        do_write(8'h00, 32'h0, 4'hF);
        hw_event_i = 32'h2;
        tick();
        hw_event_i = '0;
        tick();
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_en_gate: got %b expected 0", irq_o); end
        do_write(8'd9, 32'hFFFFFFFF, 4'b1110);
        do_read(8'd9, d, v, e);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_strobe: got %h expected 00000002", d); end
        do_write(8'd9, 32'h2, 4'h1);
        do_read(8'd9, d, v, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h expected 0", d); end
    endtask

    task automatic test_errors();
        logic [DW-1:0] d;
        logic v, e;
        status_i = {32'h5757_0003, 32'h5757_0002, 32'h5757_0001, 32'hCAFE_0000};
        do_read(8'hFF, d, v, e);
        checks++; if (d !== 32'hDEADDEAD || v !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL rd_unmapped_ff: got d=%h v=%b e=%b expected deaddead 1 1", d, v, e); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0 || bus.rd_data !== 32'hDEADDEAD) begin errors++; $display("FAIL rd_idle_hold: got v=%b e=%b d=%h expected 0 0 deaddead", bus.rd_valid, bus.rd_err, bus.rd_data); end
        do_read(8'd14, d, v, e);
        checks++; if (e !== 1'b1 || d !== 32'hDEADDEAD) begin errors++; $display("FAIL rd_unmapped_14: got e=%b d=%h expected 1 deaddead", e, d); end
        do_read(8'd13, d, v, e);
        checks++; if (e !== 1'b0 || d !== 32'h5757_0003) begin errors++; $display("FAIL rd_stat3: got e=%b d=%h expected 0 57570003", e, d); end
        do_write(8'd10, 32'hFFFFFFFF, 4'hF);
        checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_ro: got %b expected 1", bus.wr_err); end
        tick();
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_one_cycle: got %b expected 0", bus.wr_err); end
        do_read(8'd10, d, v, e);
        checks++; if (d !== 32'hCAFE_0000) begin errors++; $display("FAIL rd_stat0: got %h expected cafe0000", d); end
        do_write(8'd14, 32'h12345678, 4'hF);
        checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_unmapped: got %b expected 1", bus.wr_err); end
        do_write(8'd8, 32'h8888_0008, 4'hF);
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_last_cfg: got %b expected 0", bus.wr_err); end
        checks++; if (cfg_o[7*DW +: DW] !== 32'h8888_0008) begin errors++; $display("FAIL cfg_last_out: got %h expected 88880008", cfg_o[7*DW +: DW]); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic v, e;
        do_write(8'h01, 32'h11111111, 4'hF);
        do_write(8'h02, 32'h22222222, 4'hF);
        do_write(8'h03, 32'h33333333, 4'hF);
        do_write(8'h04, 32'h44444444, 4'hF);
        bus.rd_en = 1'b1; bus.rd_addr = 8'h01;
        bus.wr_en = 1'b1; bus.wr_addr = 8'h02; bus.wr_data = 32'hA5; bus.wr_strb = 4'hF;
        tick();
        bus.wr_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h11111111) begin errors++; $display("FAIL b2b_rd1: got v=%b d=%h expected 1 11111111", bus.rd_valid, bus.rd_data); end
        bus.rd_addr = 8'h02;
        tick();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hA5) begin errors++; $display("FAIL b2b_rd2: got v=%b d=%h expected 1 000000a5", bus.rd_valid, bus.rd_data); end
        bus.rd_addr = 8'h03;
        tick();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h33333333) begin errors++; $display("FAIL b2b_rd3: got v=%b d=%h expected 1 33333333", bus.rd_valid, bus.rd_data); end
        bus.rd_en = 1'b1; bus.rd_addr = 8'h04;
        bus.wr_en = 1'b1; bus.wr_addr = 8'h04; bus.wr_data = 32'h12345678; bus.wr_strb = 4'hF;
        tick();
        idle_inputs();
        checks++; if (bus.rd_data !== 32'h44444444) begin errors++; $display("FAIL collide_old: got %h expected 44444444", bus.rd_data); end
        checks++; if (cfg_o[3*DW +: DW] !== 32'h12345678) begin errors++; $display("FAIL collide_cfg_out: got %h expected 12345678", cfg_o[3*DW +: DW]); end
        do_read(8'h04, d, v, e);
        checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL collide_new: got %h expected 12345678", d); end
    endtask

    task automatic test_reset_abort();
        bus.rd_en = 1'b1; bus.rd_addr = 8'h01;
        bus.wr_en = 1'b1; bus.wr_addr = 8'h00; bus.wr_data = 32'h1; bus.wr_strb = 4'hF;
        #2 rst_n = 1'b0;
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.rd_valid !== 1'b0 || start_pulse_o !== 1'b0 || bus.wr_err !== 1'b0) begin errors++; $display("FAIL abort_pulses: got %b%b%b expected 000", bus.rd_valid, start_pulse_o, bus.wr_err); end
        checks++; if (cfg_o !== '0 || bus.rd_data !== '0) begin errors++; $display("FAIL abort_state: got cfg=%h rd=%h expected 0", cfg_o, bus.rd_data); end
    endtask

    initial begin
        idle_inputs();
        status_i = '0;
        test_reset();
        test_cfg_strobe();
        test_start();
        test_irq();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
